// File: rtl/cpu_mem_stage.sv
// Multi-cycle MEM pipeline stage: issues one req/ack access per instruction, stalls the pipeline while it is
// outstanding, and flags a memory that never answers. Define MEM_FWD_EN to select WB-forwarded store data.
module cpu_mem_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              fwd_sel,
    input  logic [DATA_W-1:0] wb_fdata,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t            r_state;
    state_t            w_nextState;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_memWe;
    logic [DATA_W-1:0] r_outRdata;
    logic              r_err;

    logic              w_access;
    logic              w_timeout;
    logic [DATA_W-1:0] w_storeData;

    assign w_access = in_valid & (mem_read | mem_write);

`ifdef MEM_FWD_EN
    assign w_storeData = fwd_sel ? wb_fdata : in_wdata;
`else
    logic w_unused;
    assign w_storeData = in_wdata;
    assign w_unused    = fwd_sel ^ (^wb_fdata);
`endif

    // An ack in the same cycle as the last allowed WAIT cycle counts as success, not timeout.
    assign w_timeout = (r_state == S_WAIT) & ~mem_ack & ((r_cnt + 8'd1) == TIMEOUT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        mem_req     = 1'b0;
        out_valid   = 1'b0;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_access;
                if (w_access) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                out_valid   = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        // Held-over instruction inputs must not raise stall while the stage is being reset.
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWe    <= 1'b0;
            r_outRdata <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_memAddr  <= in_addr;
                        r_memWdata <= w_storeData;
                        r_memWe    <= mem_write;
                        r_cnt      <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        if (!r_memWe) begin
                            r_outRdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign out_rdata = r_outRdata;
    assign err       = r_err;

endmodule

// File: tb/tb_cpu_mem_stage.sv
// Directed bench for cpu_mem_stage: a default-TIMEOUT instance plus a TIMEOUT=3 instance on shared inputs.
module tb_cpu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, memRead, memWrite, fwdSel, memAck, errClr;
    logic [15:0] inAddr, inWdata, wbFdata, memRdata;

    logic        stall, outValid, memReq, memWe, err;
    logic [15:0] outRdata, memAddr, memWdata;
    logic        toStall, toOutValid, toMemReq, toMemWe, toErr;
    logic [15:0] toOutRdata, toMemAddr, toMemWdata;

    int checks = 0;
    int errors = 0;
    logic [15:0] expW;

    cpu_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_addr(inAddr), .in_wdata(inWdata),
        .mem_read(memRead), .mem_write(memWrite), .fwd_sel(fwdSel), .wb_fdata(wbFdata),
        .stall(stall), .out_valid(outValid), .out_rdata(outRdata), .mem_req(memReq), .mem_we(memWe),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_ack(memAck), .mem_rdata(memRdata),
        .err(err), .err_clr(errClr)
    );

    cpu_mem_stage #(.TIMEOUT(3)) dutTo (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_addr(inAddr), .in_wdata(inWdata),
        .mem_read(memRead), .mem_write(memWrite), .fwd_sel(fwdSel), .wb_fdata(wbFdata),
        .stall(toStall), .out_valid(toOutValid), .out_rdata(toOutRdata), .mem_req(toMemReq), .mem_we(toMemWe),
        .mem_addr(toMemAddr), .mem_wdata(toMemWdata), .mem_ack(memAck), .mem_rdata(memRdata),
        .err(toErr), .err_clr(errClr)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic fwd, input logic [15:0] fdata);
        inValid  = v;
        memRead  = rd;
        memWrite = wr;
        inAddr   = addr;
        inWdata  = wdata;
        fwdSel   = fwd;
        wbFdata  = fdata;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
`ifdef MEM_FWD_EN
        expW = 16'h1234;
`else
        expW = 16'hAAAA;
`endif
        rst_n = 1'b0; memAck = 1'b0; memRdata = '0; errClr = 1'b0;
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Reset state
        cyc(); settle();
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_req", 32'(memReq), 32'h0);
        checkOutput("rst_valid", 32'(outValid), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_rdata", 32'(outRdata), 32'h0);
        checkOutput("rst_addr", 32'(memAddr), 32'h0);
        checkOutput("rst_we", 32'(memWe), 32'h0);

        // Load, ack after one WAIT cycle
        applyStimulus(1, 1, 0, 16'h0010, 16'h0, 0, 16'h0); settle();
        checkOutput("ld_acc_stall", 32'(stall), 32'h1);
        checkOutput("ld_acc_req", 32'(memReq), 32'h0);
        cyc(); settle();
        checkOutput("ld_wait_req", 32'(memReq), 32'h1);
        checkOutput("ld_wait_stall", 32'(stall), 32'h1);
        checkOutput("ld_wait_addr", 32'(memAddr), 32'h0010);
        checkOutput("ld_wait_we", 32'(memWe), 32'h0);
        memAck = 1'b1; memRdata = 16'hBEEF;
        cyc(); memAck = 1'b0; memRdata = 16'h0; settle();
        checkOutput("ld_done_valid", 32'(outValid), 32'h1);
        checkOutput("ld_done_stall", 32'(stall), 32'h0);
        checkOutput("ld_done_req", 32'(memReq), 32'h0);
        checkOutput("ld_done_rdata", 32'(outRdata), 32'hBEEF);
        cyc(); applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0); settle();
        checkOutput("ld_after_valid", 32'(outValid), 32'h0);

        // Store with forward select, ack four cycles after accept
        cyc(); applyStimulus(1, 0, 1, 16'h0020, 16'hAAAA, 1, 16'h1234); settle();
        checkOutput("st_acc_stall", 32'(stall), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i == 1) begin
                inWdata = 16'h5555; wbFdata = 16'h0000;
            end
            settle();
            checkOutput($sformatf("st_wait%0d_req", i), 32'(memReq), 32'h1);
            checkOutput($sformatf("st_wait%0d_we", i), 32'(memWe), 32'h1);
            checkOutput($sformatf("st_wait%0d_wdata", i), 32'(memWdata), 32'(expW));
            checkOutput($sformatf("st_wait%0d_addr", i), 32'(memAddr), 32'h0020);
            if (i == 4) memAck = 1'b1;
        end
        cyc(); memAck = 1'b0; settle();
        checkOutput("st_done_valid", 32'(outValid), 32'h1);
        checkOutput("st_done_rdata", 32'(outRdata), 32'hBEEF);
        checkOutput("st_done_stall", 32'(stall), 32'h0);
        cyc(); applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0); settle();

        // Stray ack in IDLE is ignored
        memAck = 1'b1; memRdata = 16'hFFFF;
        cyc(); memAck = 1'b0; memRdata = 16'h0; settle();
        checkOutput("idle_ack_valid", 32'(outValid), 32'h0);
        checkOutput("idle_ack_req", 32'(memReq), 32'h0);
        checkOutput("idle_ack_rdata", 32'(outRdata), 32'hBEEF);

        // Read and write together: store wins, load data untouched
        applyStimulus(1, 1, 1, 16'h0030, 16'h0C0C, 0, 16'h0); settle();
        checkOutput("both_acc_stall", 32'(stall), 32'h1);
        cyc(); settle();
        checkOutput("both_we", 32'(memWe), 32'h1);
        checkOutput("both_req", 32'(memReq), 32'h1);
        memAck = 1'b1; memRdata = 16'h1111;
        cyc(); memAck = 1'b0; memRdata = 16'h0; settle();
        checkOutput("both_done_valid", 32'(outValid), 32'h1);
        checkOutput("both_done_rdata", 32'(outRdata), 32'hBEEF);
        cyc(); applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0); settle();

        // Back-to-back: load, store, non-memory
        cyc(); applyStimulus(1, 1, 0, 16'h0040, 16'h0, 0, 16'h0); settle();
        checkOutput("b2b_ld_acc_req", 32'(memReq), 32'h0);
        cyc(); settle();
        checkOutput("b2b_ld_req", 32'(memReq), 32'h1);
        checkOutput("b2b_ld_addr", 32'(memAddr), 32'h0040);
        memAck = 1'b1; memRdata = 16'h5A5A;
        cyc(); memAck = 1'b0; memRdata = 16'h0; settle();
        checkOutput("b2b_ld_done_req", 32'(memReq), 32'h0);
        checkOutput("b2b_ld_done_valid", 32'(outValid), 32'h1);
        checkOutput("b2b_ld_done_rdata", 32'(outRdata), 32'h5A5A);
        cyc(); applyStimulus(1, 0, 1, 16'h0050, 16'h0F0F, 0, 16'h0); settle();
        checkOutput("b2b_st_acc_stall", 32'(stall), 32'h1);
        checkOutput("b2b_st_acc_req", 32'(memReq), 32'h0);
        cyc(); settle();
        checkOutput("b2b_st_req", 32'(memReq), 32'h1);
        checkOutput("b2b_st_we", 32'(memWe), 32'h1);
        checkOutput("b2b_st_addr", 32'(memAddr), 32'h0050);
        checkOutput("b2b_st_wdata", 32'(memWdata), 32'h0F0F);
        memAck = 1'b1;
        cyc(); memAck = 1'b0; settle();
        checkOutput("b2b_st_done_req", 32'(memReq), 32'h0);
        checkOutput("b2b_st_done_valid", 32'(outValid), 32'h1);
        cyc(); applyStimulus(1, 0, 0, 16'h0060, 16'h0, 0, 16'h0); settle();
        checkOutput("b2b_nop_stall", 32'(stall), 32'h0);
        checkOutput("b2b_nop_req", 32'(memReq), 32'h0);
        cyc(); settle();
        checkOutput("b2b_nop2_req", 32'(memReq), 32'h0);
        checkOutput("b2b_nop2_valid", 32'(outValid), 32'h0);
        checkOutput("b2b_nop2_rdata", 32'(outRdata), 32'h5A5A);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

        // Timeout on the TIMEOUT=3 instance
        cyc(); rst_n = 1'b0; #2 rst_n = 1'b1;
        cyc(); applyStimulus(1, 1, 0, 16'h0070, 16'h0, 0, 16'h0); settle();
        cyc(); settle();
        memAck = 1'b1; memRdata = 16'h7777;
        cyc(); memAck = 1'b0; memRdata = 16'h0; settle();
        checkOutput("to_pre_rdata", 32'(toOutRdata), 32'h7777);
        cyc(); applyStimulus(1, 1, 0, 16'h0080, 16'h0, 0, 16'h0); settle();
        checkOutput("to_acc_stall", 32'(toStall), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            cyc(); settle();
            checkOutput($sformatf("to_wait%0d_req", i), 32'(toMemReq), 32'h1);
            checkOutput($sformatf("to_wait%0d_err", i), 32'(toErr), 32'h0);
        end
        cyc(); settle();
        checkOutput("to_done_valid", 32'(toOutValid), 32'h1);
        checkOutput("to_done_err", 32'(toErr), 32'h1);
        checkOutput("to_done_req", 32'(toMemReq), 32'h0);
        checkOutput("to_done_stall", 32'(toStall), 32'h0);
        checkOutput("to_done_rdata", 32'(toOutRdata), 32'h7777);
        cyc(); applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0); settle();
        checkOutput("to_sticky_err", 32'(toErr), 32'h1);
        checkOutput("to_idle_req", 32'(toMemReq), 32'h0);
        errClr = 1'b1;
        cyc(); errClr = 1'b0; settle();
        checkOutput("to_clr_err", 32'(toErr), 32'h0);

        // err_clr held through a second timeout: timeout wins
        applyStimulus(1, 1, 0, 16'h0090, 16'h0, 0, 16'h0); errClr = 1'b1; settle();
        repeat (3) cyc();
        cyc(); settle();
        checkOutput("to2_done_valid", 32'(toOutValid), 32'h1);
        checkOutput("to2_done_err", 32'(toErr), 32'h1);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        cyc(); settle();
        checkOutput("to2_clr_err", 32'(toErr), 32'h0);
        errClr = 1'b0;

        // Asynchronous reset while the default instance is still waiting
        applyStimulus(1, 1, 0, 16'h00A0, 16'h0, 0, 16'h0); settle();
        checkOutput("ar_pre_req", 32'(memReq), 32'h1);
        checkOutput("ar_pre_to_stall", 32'(toStall), 32'h1);
        rst_n = 1'b0; settle();
        checkOutput("ar_req", 32'(memReq), 32'h0);
        checkOutput("ar_stall", 32'(stall), 32'h0);
        checkOutput("ar_to_stall", 32'(toStall), 32'h0);
        checkOutput("ar_valid", 32'(outValid), 32'h0);
        checkOutput("ar_err", 32'(err), 32'h0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        #1 rst_n = 1'b1;
        cyc(); settle();
        checkOutput("ar_rel_req", 32'(memReq), 32'h0);
        checkOutput("ar_rel_addr", 32'(memAddr), 32'h0);
        checkOutput("ar_rel_rdata", 32'(outRdata), 32'h0);
        applyStimulus(1, 1, 0, 16'h00B0, 16'h0, 0, 16'h0); settle();
        checkOutput("ar_idle_stall", 32'(stall), 32'h1);
        checkOutput("ar_idle_req", 32'(memReq), 32'h0);
        cyc(); settle();
        checkOutput("ar_wait_req", 32'(memReq), 32'h1);
        checkOutput("ar_wait_addr", 32'(memAddr), 32'h00B0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_stage.md
# cpu_mem_stage

Parametrised, multi-cycle MEM pipeline stage for the 16-bit CPU. It sits between the EX/MEM pipeline register and a data memory that answers with a variable-latency req/ack handshake. The stage stalls the pipeline while an access is outstanding, forwards WB data onto store data, and returns registered load data. A timeout flags a memory that never acknowledges.

## Interface
Parameters:
- DATA_W, 16, data width of load/store data.
- ADDR_W, 16, byte-address width.
- TIMEOUT, 15, WAIT-state cycles before an access is abandoned; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EX/MEM register holds a valid instruction.
- in_addr  in  ADDR_W  access address (ALU result).
- in_wdata  in  DATA_W  store data (register B).
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- fwd_sel  in  1  MEM-to-MEM forward select for store data.
- wb_fdata  in  DATA_W  forwarded data from WB.
- stall  out  1  freeze PC and IF/ID, ID/EX and EX/MEM registers.
- out_valid  out  1  one-cycle pulse: memory access completed.
- out_rdata  out  DATA_W  registered load data to the MEM/WB register.
- mem_req  out  1  request to data memory.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err synchronously.

## Operation
- Access = in_valid & (mem_read | mem_write). If both are set, the write wins: a store is issued and out_rdata is unchanged.
- FSM states are IDLE, WAIT and DONE.
- IDLE:
  - On an access, latch in_addr, the store data and mem_we, clear the timeout counter, and go to WAIT.
  - With no access, remain in IDLE.
- WAIT:
  - mem_req = 1. mem_addr, mem_we and mem_wdata are held stable.
  - On mem_ack, capture mem_rdata into out_rdata (loads only) and go to DONE.
  - Otherwise increment the counter. If the counter reaches TIMEOUT, set err, leave out_rdata unchanged, and go to DONE.
- DONE: out_valid = 1 and all inputs are ignored; the next state is IDLE. DONE exists so that the still-held instruction is not re-issued.
- stall = (state==IDLE & access) | (state==WAIT). stall is combinational and is 0 in DONE.
- A mem_ack seen in IDLE or DONE is ignored.
- err_clr and a simultaneous timeout: the timeout wins and err stays 1.
- Reset values (also on mid-access reset): state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, out_rdata 0, out_valid 0, err 0, counter 0.
- An asynchronous reset drops mem_req immediately; an in-flight access is abandoned.

## Timing
- Accept cycle N (IDLE, access): stall=1, mem_req=0.
- Cycle N+1 onward: WAIT with mem_req=1.
- If mem_ack arrives in cycle N+k (k≥1), DONE is cycle N+k+1, with out_valid=1 and out_rdata valid.
- The pipeline advances at the end of DONE.
- Minimum stall is 2 cycles (k=1). Total access latency is k+1 cycles.
- Timeout: with no ack, DONE is cycle N+TIMEOUT+1 and err=1 from that cycle.
- Back-to-back accesses: the next instruction is accepted in the cycle after DONE.

## Configuration
- MEM_FWD_EN defined: latched store data = fwd_sel ? wb_fdata : in_wdata.
- MEM_FWD_EN undefined: latched store data = in_wdata. fwd_sel and wb_fdata remain as ports but are ignored.

## Test plan
- Reset: drive rst_n=0 mid-WAIT -> mem_req, stall, out_valid and err are 0 immediately; the FSM is in IDLE after release.
- Load, ack after 1 cycle: in_addr=0x0010, mem_rdata=0xBEEF -> stall high for 2 cycles, out_valid pulses in the 3rd cycle, out_rdata=0xBEEF.
- Store with forwarding (MEM_FWD_EN): fwd_sel=1, wb_fdata=0x1234, in_wdata=0xAAAA -> mem_we=1, mem_wdata=0x1234, held until ack 4 cycles later.
- Store without MEM_FWD_EN, same stimulus -> mem_wdata=0xAAAA.
- Timeout with TIMEOUT=3 and no ack -> mem_req high for 3 cycles, then DONE; err=1 and stays set until err_clr; out_rdata unchanged.
- Back-to-back: load, then store, then a non-memory instruction -> two distinct mem_req bursts with no re-issue in DONE; stall=0 for the non-memory instruction.
